// File: rtl/dds_freq_meter.sv
// dds_freq_meter: hysteretic mid-scale crossing period meter; FREQ_METER_FWORD_EN adds frequency-word recovery
module dds_freq_meter #(
  parameter int unsigned DATA_W      = 14,
  parameter int unsigned MID         = 8192,
  parameter int unsigned HYST        = 64,
  parameter int unsigned NUM_PERIODS = 16,
  parameter logic [31:0] TIMEOUT_CYC = 32'h0100_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [DATA_W-1:0] din_i,
  input  logic              din_valid_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              timeout_o,
  output logic [31:0]       period_cnt_o,
  output logic [31:0]       fword_est_o
);
  localparam logic [DATA_W:0] HI     = (DATA_W+1)'(MID + HYST);
  localparam logic [DATA_W:0] LO     = (DATA_W+1)'(MID - HYST);
  localparam logic [8:0]      P_LAST = 9'(NUM_PERIODS - 1);
  typedef enum logic [2:0] {
    IDLE,
    ARM,
    COUNT,
`ifdef FREQ_METER_FWORD_EN
    DIV,
`endif
    DONE
  } state_t;
  state_t            state_q, state_d;
  logic [DATA_W-1:0] din_q;
  logic              vld_q, s_q, s_d, x_q;
  logic [31:0]       c_q, c_d, wd_q, wd_d, period_q, period_d;
  logic [8:0]        p_q, p_d;
  logic              timeout_q, timeout_d, wd_lim, last, abort;
  // Schmitt trigger on the registered sample; held through invalid samples
  assign s_d    = !vld_q ? s_q :
                  ({1'b0, din_q} >= HI) ? 1'b1 :
                  ({1'b0, din_q} <  LO) ? 1'b0 : s_q;
  assign wd_lim = wd_q >= TIMEOUT_CYC - 32'd1;
  assign last   = x_q && p_q == P_LAST;
  assign abort  = wd_lim && ((state_q == ARM && !x_q) || (state_q == COUNT && !last));
`ifdef FREQ_METER_FWORD_EN
  logic [31:0] r_q, r_d, q_q, q_d, fword_q, fword_d;
  logic [32:0] r_sh;
  logic [5:0]  k_q, k_d;
  logic        ge;
  assign r_sh = {r_q, 1'b0};
  assign ge   = r_sh >= {1'b0, period_q};
`endif
  // Measurement sequencing, counters and the restoring divider step
  always_comb begin
    state_d   = state_q;
    c_d       = c_q + 32'd1;
    p_d       = p_q;
    wd_d      = wd_q + 32'd1;
    timeout_d = timeout_q;
    period_d  = period_q;
`ifdef FREQ_METER_FWORD_EN
    fword_d   = fword_q;
    r_d       = r_q;
    q_d       = q_q;
    k_d       = '0;
`endif
    case (state_q)
      IDLE: begin
        wd_d = '0;
        if (start_i) begin
          state_d   = ARM;
          timeout_d = 1'b0;
        end
      end
      ARM: begin
        c_d = '0;
        p_d = '0;
        if (x_q) state_d = COUNT;
      end
      COUNT: begin
        p_d = p_q + 9'(x_q);
        if (last) begin
          period_d = c_q + 32'd1;
`ifdef FREQ_METER_FWORD_EN
          state_d  = DIV;
`else
          state_d  = DONE;
`endif
        end
      end
`ifdef FREQ_METER_FWORD_EN
      DIV: begin
        k_d = k_q + 6'd1;
        r_d = (k_q == 6'd0) ? 32'(NUM_PERIODS) : ge ? 32'(r_sh - {1'b0, period_q}) : r_sh[31:0];
        q_d = (k_q == 6'd0) ? '0 : {q_q[30:0], ge};
        if (k_q == 6'd32) begin
          state_d = DONE;
          fword_d = (period_q <= 32'(NUM_PERIODS)) ? '1 : {q_q[30:0], ge};
        end
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d   = DONE;
      timeout_d = 1'b1;
      period_d  = '0;
`ifdef FREQ_METER_FWORD_EN
      fword_d   = '0;
`endif
    end
  end
  // State, input stage, Schmitt state and crossing pulse registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      din_q     <= '0;
      vld_q     <= 1'b0;
      s_q       <= 1'b0;
      x_q       <= 1'b0;
      c_q       <= '0;
      p_q       <= '0;
      wd_q      <= '0;
      timeout_q <= 1'b0;
      period_q  <= '0;
`ifdef FREQ_METER_FWORD_EN
      fword_q   <= '0;
      r_q       <= '0;
      q_q       <= '0;
      k_q       <= '0;
`endif
    end else begin
      state_q   <= state_d;
      din_q     <= din_i;
      vld_q     <= din_valid_i;
      s_q       <= s_d;
      x_q       <= s_d & ~s_q;
      c_q       <= c_d;
      p_q       <= p_d;
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
      period_q  <= period_d;
`ifdef FREQ_METER_FWORD_EN
      fword_q   <= fword_d;
      r_q       <= r_d;
      q_q       <= q_d;
      k_q       <= k_d;
`endif
    end
  end
  assign busy_o       = state_q != IDLE && state_q != DONE;
  assign done_o       = state_q == DONE;
  assign timeout_o    = timeout_q;
  assign period_cnt_o = period_q;
`ifdef FREQ_METER_FWORD_EN
  assign fword_est_o  = fword_q;
`else
  assign fword_est_o  = '0;
`endif
endmodule
